muldiv_ctrl: RTL and testbench

Sequencer for the CPU's iterative `mult` and `div` units and the shared Hi/Lo registers. The main `control_unit` issues a one-cycle multiply or divide request and continues with other states. `muldiv_ctrl` then does four things:
- starts the selected unit and counts its fixed latency;
- steers `mux_hi_select`/`mux_lo_select` and pulses `HiLo_load`;
- reports divide-by-zero;
- stalls `mfhi`/`mflo` reads that arrive while an operation is outstanding.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        WRITE    = 2'd3
    } muldiv_state_t;

    localparam logic SEL_DIV  = 1'b0;
    localparam logic SEL_MULT = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative MULT/DIV units: starts the unit, counts its latency,
// loads Hi/Lo, flags divide-by-zero and dropped requests, and stalls early Hi/Lo reads.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        div_req,
    input  logic [31:0] divisor,
    input  logic        hilo_read,
    output logic        mult_start,
    output logic        div_start,
    output logic        HiLo_load,
    output logic        sel_mux_hi,
    output logic        sel_mux_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        req_err,
    output logic        stall
);

    localparam int unsigned MAX_CYCLES = max_u(MULT_CYCLES, DIV_CYCLES);
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel, sel_nxt;
    logic             mult_start_q, mult_start_nxt;
    logic             div_start_q, div_start_nxt;
    logic             load_q, load_nxt;
    logic             busy_q, busy_nxt;
    logic             div_zero_q, div_zero_nxt;
    logic             req_err_q, req_err_nxt;

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sel          <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            div_zero_q   <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sel          <= sel_nxt;
            mult_start_q <= mult_start_nxt;
            div_start_q  <= div_start_nxt;
            load_q       <= load_nxt;
            busy_q       <= busy_nxt;
            div_zero_q   <= div_zero_nxt;
            req_err_q    <= req_err_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = sel;
        mult_start_nxt = 1'b0;
        div_start_nxt  = 1'b0;
        load_nxt       = 1'b0;
        div_zero_nxt   = 1'b0;
        req_err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (mult_req) begin
                    // Multiply wins a collision; the divide is reported as dropped
                    state_nxt      = MULT_RUN;
                    cnt_nxt        = MULT_LOAD;
                    sel_nxt        = SEL_MULT;
                    mult_start_nxt = 1'b1;
                    req_err_nxt    = div_req;
                end else if (div_req) begin
                    if (divisor == 32'd0) begin
                        div_zero_nxt = 1'b1;
                    end else begin
                        state_nxt     = DIV_RUN;
                        cnt_nxt       = DIV_LOAD;
                        sel_nxt       = SEL_DIV;
                        div_start_nxt = 1'b1;
                    end
                end
            end
            MULT_RUN, DIV_RUN: begin
                req_err_nxt = mult_req | div_req;
                if (cnt == '0) begin
                    state_nxt = WRITE;
                    load_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WRITE: begin
                req_err_nxt = mult_req | div_req;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign HiLo_load  = load_q;
    assign done       = load_q;
    assign sel_mux_hi = sel;
    assign sel_mux_lo = sel;
    assign busy       = busy_q;
    assign div_zero   = div_zero_q;
    assign req_err    = req_err_q;

    // A read in WRITE still stalls: Hi/Lo only update at the end of that cycle
    assign stall = hilo_read & busy_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with default 32-cycle latencies.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_req;
    logic        div_req;
    logic [31:0] divisor;
    logic        hilo_read;
    logic        mult_start;
    logic        div_start;
    logic        HiLo_load;
    logic        sel_mux_hi;
    logic        sel_mux_lo;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        req_err;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .mult_req   (mult_req),
        .div_req    (div_req),
        .divisor    (divisor),
        .hilo_read  (hilo_read),
        .mult_start (mult_start),
        .div_start  (div_start),
        .HiLo_load  (HiLo_load),
        .sel_mux_hi (sel_mux_hi),
        .sel_mux_lo (sel_mux_lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .req_err    (req_err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request during the current cycle; returns in cycle 1 of the operation
    task automatic issue(input logic m, input logic d, input logic [31:0] dv);
        mult_req = m;
        div_req  = d;
        divisor  = dv;
        tick();
        mult_req = 1'b0;
        div_req  = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".mult_start"}, mult_start, 0);
        check({nm, ".div_start"},  div_start,  0);
        check({nm, ".HiLo_load"},  HiLo_load,  0);
        check({nm, ".done"},       done,       0);
        check({nm, ".sel_hi"},     sel_mux_hi, 0);
        check({nm, ".sel_lo"},     sel_mux_lo, 0);
        check({nm, ".busy"},       busy,       0);
        check({nm, ".div_zero"},   div_zero,   0);
        check({nm, ".req_err"},    req_err,    0);
        check({nm, ".stall"},      stall,      0);
    endtask

    // Observe cycles 1..34 of an operation of latency 32; optionally inject a
    // div_req in cycle inj and hold hilo_read from cycle rd onward.
    task automatic op_watch(input string nm, input logic is_mult, input logic err1,
                            input int inj, input int rd);
        logic exp_sel;
        exp_sel = is_mult ? 1'b1 : 1'b0;
        for (int k = 1; k <= 34; k++) begin
            hilo_read = (k >= rd);
            #1;
            check($sformatf("%s.mult_start@%0d", nm, k), mult_start, is_mult && k == 1);
            check($sformatf("%s.div_start@%0d", nm, k),  div_start,  !is_mult && k == 1);
            check($sformatf("%s.busy@%0d", nm, k),       busy,       k <= 33);
            check($sformatf("%s.HiLo_load@%0d", nm, k),  HiLo_load,  k == 33);
            check($sformatf("%s.done@%0d", nm, k),       done,       k == 33);
            check($sformatf("%s.sel_hi@%0d", nm, k),     sel_mux_hi, exp_sel);
            check($sformatf("%s.sel_lo@%0d", nm, k),     sel_mux_lo, exp_sel);
            check($sformatf("%s.div_zero@%0d", nm, k),   div_zero,   0);
            check($sformatf("%s.req_err@%0d", nm, k),    req_err,
                  (err1 && k == 1) || (k == inj + 1));
            check($sformatf("%s.stall@%0d", nm, k),      stall,      (k >= rd) && (k <= 33));
            div_req = (k == inj);
            divisor = 32'd3;
            if (k < 34) tick();
        end
        hilo_read = 1'b0;
        div_req   = 1'b0;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mult_req  = 1'b0;
        div_req   = 1'b0;
        divisor   = 32'd0;
        hilo_read = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset     = 1'b0;
        hilo_read = 1'b0;
        tick();
        check_all_zero("idle");

        // 1: plain multiply
        issue(1'b1, 1'b0, 32'd0);
        op_watch("mult", 1'b1, 1'b0, 100, 100);

        // 2: divide issued back-to-back in cycle N+2; div_req in WRITE is dropped
        issue(1'b0, 1'b1, 32'd7);
        op_watch("div", 1'b0, 1'b0, 33, 100);

        // prior op was a divide; run a multiply so selects are 1 before div-by-zero
        issue(1'b1, 1'b0, 32'd0);
        op_watch("mult2", 1'b1, 1'b0, 100, 100);

        // 3: divide by zero
        issue(1'b0, 1'b1, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("dz.div_zero@%0d", k),  div_zero,   k == 1);
            check($sformatf("dz.busy@%0d", k),      busy,       0);
            check($sformatf("dz.div_start@%0d", k), div_start,  0);
            check($sformatf("dz.HiLo_load@%0d", k), HiLo_load,  0);
            check($sformatf("dz.sel_hi@%0d", k),    sel_mux_hi, 1);
            check($sformatf("dz.sel_lo@%0d", k),    sel_mux_lo, 1);
            tick();
        end

        // 4: collision, then a divide request at cycle 10
        issue(1'b1, 1'b1, 32'd5);
        op_watch("coll", 1'b1, 1'b1, 10, 100);

        // 5: stall from cycle 5
        issue(1'b1, 1'b0, 32'd0);
        op_watch("stall", 1'b1, 1'b0, 100, 5);

        // 6: reset at cycle 20 of a divide
        issue(1'b0, 1'b1, 32'd9);
        for (int k = 1; k < 20; k++) tick();
        check("rst.busy@20", busy, 1);
        reset     = 1'b1;
        hilo_read = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst@21");
        hilo_read = 1'b0;
        tick();
        check_all_zero("rst@22");
        issue(1'b1, 1'b0, 32'd0);
        op_watch("after_rst", 1'b1, 1'b0, 100, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
